serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing a - b - bin, LSB first, one bit per clock. It is built around a single full-subtractor cell and a borrow flip-flop. It is the inverse arithmetic counterpart of the existing full-adder datapath and serves area-constrained paths where latency is acceptable. It uses a start/busy/done handshake with parallel operand load and parallel result output.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1 to 32.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  minuend; captured on the accepted start edge.
b  input  WIDTH  subtrahend; captured on the accepted start edge.
bin  input  1  initial borrow-in; captured on the accepted start edge.
diff  output  WIDTH  registered result; holds until the next DONE.
bout  output  1  registered final borrow-out (1 = a < b + bin); holds with diff.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset: state=IDLE; diff=0, bout=0, busy=0, done=0; internal shift registers, borrow flop and bit counter all cleared.
- rst has priority over every other input. rst asserted mid-RUN aborts the operation: no done pulse, diff/bout forced to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on an edge with start=1. On that edge: load a_sr=a, b_sr=b, borrow=bin, cnt=0.
  - RUN: each edge computes d = a_sr[0]^b_sr[0]^borrow and nb = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow).
  - RUN, each edge (continued): shift a_sr and b_sr right; shift d into the MSB of res_sr; borrow=nb; cnt=cnt+1.
  - RUN -> DONE on the edge where cnt==WIDTH-1 (the WIDTH-th bit). On that same edge, diff and bout load the final res_sr value and the final borrow.
  - DONE -> IDLE unconditionally after one cycle.
- Latency: start sampled at edge E0; done=1 during the cycle after edge E0+WIDTH; IDLE again after edge E0+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously is re-accepted in the first IDLE cycle.
- start during RUN or DONE: ignored. Changes on a, b or bin after acceptance have no effect.
- diff and bout change only on the RUN->DONE edge and on reset. They are stable at all other times, including throughout the next RUN.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH. bout = 1 iff a < b + bin, compared as unsigned with WIDTH+1 bits.
- WIDTH=1: RUN lasts exactly one cycle. cnt width is clog2(WIDTH) with a minimum of 1.
- done and busy are registered outputs (derived from the state register), not combinational from start.

Decomposition:
- Shared package serial_arith_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the clog2 function used for the counter width.
- One sub-module, full_subtractor: purely combinational, ports in order (diff, bout, a, b, bin). It is instantiated once as the per-bit cell. It has its own small exhaustive bench with 8 input combinations.

Test Plan:
- full_subtractor exhaustive, 8 combinations at 10-time-unit spacing -> (a,b,bin)=011 gives diff=0,bout=1; 100 gives diff=1,bout=0; 111 gives diff=1,bout=1. Remaining rows match a-b-bin.
- WIDTH=4, a=9, b=5, bin=0, start pulsed at E0 -> busy=1 from E0+1; done=1 in the cycle after E0+4; diff=4, bout=0.
- WIDTH=4, a=5, b=9, bin=0 -> diff=12 (1100), bout=1. Case a=0, b=0, bin=1 -> diff=15, bout=1.
- Start while busy: second start with a=1, b=1 issued during RUN -> ignored; first result (9-5=4) is delivered intact; exactly one done pulse.
- rst asserted two cycles into RUN -> next cycle state=IDLE, busy=0, diff=0, no done pulse. A fresh start with a=15, b=15 then gives diff=0, bout=0.
- start held high continuously with a=8, b=3 -> done pulses every 6 cycles (WIDTH+2); diff=5 on every pulse.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapaths.
// Holds the sequencer state encoding and a constant clog2 used to size counters.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: computes a - b - bin.
// Ports: diff (difference bit), bout (borrow out), a (minuend bit), b (subtrahend bit), bin (borrow in).
// Latency: combinational. Backpressure: none.
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they are equal and a borrow arrives.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff/bout = a - b - bin, LSB first, one bit per clock.
// Ports: clk, rst (sync, active-high); start/a/b/bin request with parallel operand load;
//   diff/bout registered result; busy high in RUN and DONE; done one-cycle pulse.
// Latency: start at edge E0 -> done in the cycle after E0+WIDTH; start ignored while busy.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_cell (
    .diff (cell_diff),
    .bout (cell_bout),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow)
  );

  // New difference bit enters at the MSB; written via a WIDTH+1 vector so the
  // slice stays legal when WIDTH is 1.
  assign res_ext   = {cell_diff, res_sr};
  assign res_shift = res_ext[WIDTH:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_shift;
          borrow <= cell_bout;
          cnt    <= cnt + CW'(1);
          busy   <= 1'b1;
          if (cnt == LAST) begin
            // Last bit: publish the assembled result and final borrow together.
            state <= DONE;
            diff  <= res_shift;
            bout  <= cell_bout;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  logic fa, fb, fbin, fs_d, fs_bo;

  int total = 0;
  int bad   = 0;
  int last_diff = 0;
  int last_bout = 0;

  typedef struct {
    int a;
    int b;
    int bin;
    int exp_diff;
    int exp_bout;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  full_subtractor u_fs (
    .diff (fs_d),
    .bout (fs_bo),
    .a    (fa),
    .b    (fb),
    .bin  (fbin)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic int ref_diff(input int x, input int y, input int c);
    int t;
    t = x - y - c;
    return t & ((1 << W) - 1);
  endfunction

  function automatic int ref_bout(input int x, input int y, input int c);
    return (x < y + c) ? 1 : 0;
  endfunction

  // Called #1 after a rising edge with the DUT idle. Pulses start, optionally
  // scrambles the operand inputs while running, and checks timing and result.
  task automatic run_op(input int x, input int y, input int c, input bit scramble,
                        input string tag);
    int seen;
    bit moved;
    int ed, eb;
    ed = ref_diff(x, y, c);
    eb = ref_bout(x, y, c);
    start = 1'b1;
    a = W'(x);
    b = W'(y);
    bin = c[0];
    @(posedge clk);            // E0
    #1;
    start = 1'b0;
    chk({tag, ".busy_after_start"}, int'(busy), 1);
    seen = 0;
    moved = 1'b0;
    for (int i = 1; i <= W + 6; i++) begin
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
      end
      if (int'(diff) != last_diff || int'(bout) != last_bout) moved = 1'b1;
      @(posedge clk);
      #1;
      if (done) begin
        seen = i;
        break;
      end
    end
    if (seen == 0) begin
      chk({tag, ".done_timeout"}, 0, 1);
    end else begin
      chk({tag, ".latency"}, seen, W);
      chk({tag, ".stable_while_run"}, int'(moved), 0);
      chk({tag, ".diff"}, int'(diff), ed);
      chk({tag, ".bout"}, int'(bout), eb);
      @(posedge clk);
      #1;
      chk({tag, ".done_one_cycle"}, int'(done), 0);
      chk({tag, ".idle_after"}, int'(busy), 0);
      last_diff = ed;
      last_bout = eb;
    end
  endtask

  initial begin
    int pulses;
    int prev_pulse;
    int rx, ry, rc;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    fa = 1'b0;
    fb = 1'b0;
    fbin = 1'b0;

    // Full subtractor cell, exhaustive.
    for (int k = 0; k < 8; k++) begin
      int t;
      fa = k[2];
      fb = k[1];
      fbin = k[0];
      #10;
      t = int'(fa) - int'(fb) - int'(fbin);
      chk($sformatf("fs.diff[%0d]", k), int'(fs_d), t & 1);
      chk($sformatf("fs.bout[%0d]", k), int'(fs_bo), (t < 0) ? 1 : 0);
    end

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.diff", int'(diff), 0);
    chk("reset.bout", int'(bout), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);

    // Directed table.
    vecs[0] = '{9, 5, 0, 4, 0};
    vecs[1] = '{5, 9, 0, 12, 1};
    vecs[2] = '{0, 0, 1, 15, 1};
    vecs[3] = '{15, 15, 0, 0, 0};
    vecs[4] = '{15, 0, 1, 14, 0};
    vecs[5] = '{0, 15, 1, 0, 1};
    vecs[6] = '{8, 3, 0, 5, 0};
    vecs[7] = '{7, 7, 1, 15, 1};
    for (int v = 0; v < 8; v++) begin
      chk($sformatf("table%0d.model", v), ref_diff(vecs[v].a, vecs[v].b, vecs[v].bin),
          vecs[v].exp_diff);
      run_op(vecs[v].a, vecs[v].b, vecs[v].bin, 1'b0, $sformatf("table%0d", v));
      chk($sformatf("table%0d.exp_diff", v), int'(diff), vecs[v].exp_diff);
      chk($sformatf("table%0d.exp_bout", v), int'(bout), vecs[v].exp_bout);
    end

    // Start while busy is ignored.
    start = 1'b1;
    a = 4'd9;
    b = 4'd5;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 4'd1;
    b = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        chk("busy_start.diff", int'(diff), 4);
      end
      @(posedge clk);
      #1;
    end
    chk("busy_start.pulses", pulses, 1);
    last_diff = 4;
    last_bout = 0;

    // Reset two cycles into RUN aborts the operation.
    start = 1'b1;
    a = 4'd9;
    b = 4'd5;
    @(posedge clk);            // E0
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    chk("abort.diff", int'(diff), 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort.no_done", pulses, 0);
    last_diff = 0;
    last_bout = 0;
    run_op(15, 15, 0, 1'b0, "after_abort");

    // Start held high: one result every W+2 cycles.
    start = 1'b1;
    a = 4'd8;
    b = 4'd3;
    bin = 1'b0;
    pulses = 0;
    prev_pulse = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        chk("held.diff", int'(diff), 5);
        if (prev_pulse >= 0) chk("held.period", i - prev_pulse, W + 2);
        prev_pulse = i;
      end
    end
    start = 1'b0;
    chk("held.enough_pulses", int'(pulses >= 5), 1);
    for (int i = 0; i < 12 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    chk("held.drained", int'(busy), 0);
    last_diff = 5;
    last_bout = 0;

    // Random operands, inputs scrambled after acceptance.
    for (int r = 0; r < 40; r++) begin
      rx = int'($urandom_range(0, (1 << W) - 1));
      ry = int'($urandom_range(0, (1 << W) - 1));
      rc = int'($urandom_range(0, 1));
      run_op(rx, ry, rc, 1'b1, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
